result_uart_tx: RTL

RESULT_UART_TX -- requirements
Module: result_uart_tx

---
 rtl/result_uart_tx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: serialises 5-bit classifier results onto a UART line.
// Results are queued in a small FIFO and sent as {3'b000, result} bytes,
// LSB first, with one start bit and one stop bit. Each bit lasts CLKS_PER_BIT
// clocks, and back-to-back frames are sent with no idle gap between them.
//
// Optional feature: define RESULT_UART_TX_PARITY_EN to append an even-parity
// bit after data bit 7. The default build has no parity state or logic.
//
// FSM states:
//   state  | meaning
//   IDLE   | line idle (high), waiting for the FIFO to become non-empty
//   START  | start bit (low) on the line
//   DATA   | data bits 0..7, LSB first
//   PARITY | even parity of the data byte (only with RESULT_UART_TX_PARITY_EN)
//   STOP   | stop bit (high); at its end, chains to START if more data waits
//
// The serial line is registered one cycle behind the state register. Because
// of that, a result strobed into an idle block reaches the line (start bit)
// two edges after it is sampled.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       result_data_valid,
  input  logic [4:0] result_data,
  output logic       tx_o,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

`ifdef RESULT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // result FIFO
  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [4:0]    fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          drop;

  // transmitter
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic          baud_done;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line;
  logic          busy_nxt;
`ifdef RESULT_UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign baud_done  = (baud_cnt == '0);

  // A new frame is loaded from IDLE right away, or at the last stop-bit cycle
  // so that the next start bit follows the stop bit with no gap.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push = result_data_valid && (!fifo_full || pop);
  assign drop = result_data_valid && fifo_full && !pop;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // busy covers a queued result and the final stop-bit cycle still on the line
  assign busy_nxt = (state != IDLE) || pop || (count_nxt != '0);

  // serial line value for the current state, registered into tx_o
  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shreg[0];
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY:  line = parity_bit;
`endif
      default: line = 1'b1;
    endcase
  end

  // FIFO storage; the pointers are reset, so stale contents are never read
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr] <= result_data;
    end
  end

  // FIFO pointers and occupancy, wrapping modulo FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

  // transmit FSM with baud down-counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx_o       <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tx_o     <= line;
      busy     <= busy_nxt;
      overflow <= drop;
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= {3'b000, fifo_head};
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
            parity_bit <= ^fifo_head;
`endif
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
`ifdef RESULT_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state    <= STOP;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              state    <= START;
              shreg    <= {3'b000, fifo_head};
              baud_cnt <= BAUD_LOAD;
              bit_idx  <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
              parity_bit <= ^fifo_head;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule
